// File: rtl/c_fetch_queue.sv
// c_fetch_queue: circular fetch-word queue exposing the two oldest entries, 0/1/2 retire per cycle
module c_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       icache_valid_i,
  input  logic [XLEN-1:0]            icache_instr_i,
  input  logic [XLEN-1:0]            icache_pc_i,
  output logic                       fetch_ready_o,
  input  logic [1:0]                 deq_cnt_i,
  output logic                       q_valid_o,
  output logic [XLEN-1:0]            q_instr_o,
  output logic [XLEN-1:0]            q_pc_o,
  output logic                       q_valid2_o,
  output logic [XLEN-1:0]            q_instr2_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr2;
  logic [CW-1:0]   count;
  logic            err, push, pop_ok;
  logic [1:0]      pop_amt;
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  assign fetch_ready_o = count < CW'(DEPTH);
  assign push          = icache_valid_i & fetch_ready_o & ~flush_i;
  assign pop_ok        = (deq_cnt_i != 2'd3) && (CW'(deq_cnt_i) <= count);
  assign pop_amt       = pop_ok ? deq_cnt_i : 2'd0;
  assign rd_ptr2       = rd_ptr + AW'(1);
  assign q_valid_o     = count >= CW'(1);
  assign q_valid2_o    = count >= CW'(2);
  assign q_instr_o     = q_valid_o ? instr_mem[rd_ptr] : '0;
  assign q_pc_o        = q_valid_o ? pc_mem[rd_ptr] : '0;
  assign q_instr2_o    = q_valid2_o ? instr_mem[rd_ptr2] : '0;
  assign count_o       = count;
  assign err_o         = err;
  // pointers, occupancy and sticky error; flush empties the queue but leaves err alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_amt);
      count  <= count + CW'(push) - CW'(pop_amt);
      if (!pop_ok || (icache_valid_i && !fetch_ready_o)) err <= 1'b1;
    end
  end
  // storage needs no reset: outputs are gated by the valid flags
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= icache_instr_i;
      pc_mem[wr_ptr]    <= {icache_pc_i[XLEN-1:2], 2'b00};
    end
  end
endmodule

// File: tb/tb_c_fetch_queue.sv
// tb_c_fetch_queue: scoreboard bench for c_fetch_queue (DEPTH=4, XLEN=32)
module tb_c_fetch_queue;
  logic        clk = 0, reset = 0, flush_i = 0, icache_valid_i = 0;
  logic [31:0] icache_instr_i = 0, icache_pc_i = 0;
  logic [1:0]  deq_cnt_i = 0;
  logic        fetch_ready_o, q_valid_o, q_valid2_o, err_o;
  logic [31:0] q_instr_o, q_pc_o, q_instr2_o;
  logic [2:0]  count_o;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t sb[$];
  logic merr = 0;
  int checks = 0, errors = 0;

  c_fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .icache_valid_i(icache_valid_i),
    .icache_instr_i(icache_instr_i), .icache_pc_i(icache_pc_i), .fetch_ready_o(fetch_ready_o),
    .deq_cnt_i(deq_cnt_i), .q_valid_o(q_valid_o), .q_instr_o(q_instr_o), .q_pc_o(q_pc_o),
    .q_valid2_o(q_valid2_o), .q_instr2_o(q_instr2_o), .count_o(count_o), .err_o(err_o));

  always #5 clk = ~clk;

  // update the reference model from the pre-edge state, then drive one clock cycle
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [1:0] d, input logic f);
    int n;
    n = sb.size();
    if (f) sb.delete();
    else begin
      if (d == 2'd3 || int'(d) > n) merr = 1;
      else repeat (int'(d)) void'(sb.pop_front());
      if (v) begin
        if (n < 4) sb.push_back({ins, pc[31:2], 2'b00});
        else merr = 1;
      end
    end
    icache_valid_i = v; icache_instr_i = ins; icache_pc_i = pc; deq_cnt_i = d; flush_i = f;
    @(posedge clk); #1;
    icache_valid_i = 0; deq_cnt_i = 0; flush_i = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    #12;
    checks++;
    if ({q_valid_o, q_valid2_o, err_o, count_o} !== 6'b0 || fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got v=%b v2=%b err=%b cnt=%0d rdy=%b want 0 0 0 0 1",
               q_valid_o, q_valid2_o, err_o, count_o, fetch_ready_o);
    end
    checks++;
    if ({q_instr_o, q_pc_o, q_instr2_o} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h want zeros", q_instr_o, q_pc_o, q_instr2_o);
    end
    @(posedge clk); #1;
    reset = 1;
    sb.delete(); merr = 0;
  endtask

  task automatic test_fill;
    logic [31:0] ins [4] = '{32'h00000013, 32'h00A00093, 32'h45014581, 32'hFFFF0001};
    for (int i = 0; i < 4; i++) begin
      step(1, ins[i], 32'h80000000 + 32'(4 * i), 0, 0);
      checks++;
      if (count_o !== 3'(sb.size()) || fetch_ready_o !== (sb.size() < 4)) begin
        errors++;
        $display("FAIL fill_count[%0d]: got cnt=%0d rdy=%b want cnt=%0d rdy=%b",
                 i, count_o, fetch_ready_o, sb.size(), sb.size() < 4);
      end
    end
    checks++;
    if (count_o !== 3'd4 || fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got cnt=%0d rdy=%b want 4 0", count_o, fetch_ready_o);
    end
    checks++;
    if (q_instr_o !== 32'h00000013 || q_instr2_o !== 32'h00A00093 || q_pc_o !== sb[0].pc) begin
      errors++;
      $display("FAIL fill_peek: got %h %h pc=%h want 00000013 00a00093 pc=%h",
               q_instr_o, q_instr2_o, q_pc_o, sb[0].pc);
    end
  endtask

  task automatic test_overflow;
    step(1, 32'hDEADBEEF, 32'h80000010, 1, 0);
    checks++;
    if (err_o !== 1'b1 || count_o !== 3'd3 || q_pc_o !== 32'h80000004) begin
      errors++;
      $display("FAIL overflow: got err=%b cnt=%0d pc=%h want 1 3 80000004", err_o, count_o, q_pc_o);
    end
    checks++;
    if (q_instr_o !== sb[0].instr || q_instr2_o !== sb[1].instr) begin
      errors++;
      $display("FAIL overflow_peek: got %h %h want %h %h", q_instr_o, q_instr2_o, sb[0].instr, sb[1].instr);
    end
  endtask

  task automatic test_pop2_push;
    step(0, 0, 0, 1, 0);
    checks++;
    if (count_o !== 3'd2 || q_pc_o !== 32'h80000008) begin
      errors++;
      $display("FAIL pop1: got cnt=%0d pc=%h want 2 80000008", count_o, q_pc_o);
    end
    step(1, 32'h12345678, 32'h80000010, 2, 0);
    checks++;
    if (count_o !== 3'd1 || q_instr_o !== 32'h12345678 || q_valid2_o !== 1'b0 ||
        q_instr2_o !== 32'h0 || q_pc_o !== sb[0].pc) begin
      errors++;
      $display("FAIL pop2_push: got cnt=%0d ins=%h v2=%b ins2=%h pc=%h want 1 12345678 0 0 %h",
               count_o, q_instr_o, q_valid2_o, q_instr2_o, q_pc_o, sb[0].pc);
    end
  endtask

  task automatic test_wrap;
    step(0, 0, 0, 0, 1);
    step(1, 32'hA0000000, 32'h100, 0, 0);
    for (int i = 1; i < 10; i++) begin
      step(1, 32'hA0000000 + 32'(i), 32'h100 + 32'(4 * i), 1, 0);
      checks++;
      if (q_pc_o !== 32'h100 + 32'(4 * i) || q_pc_o !== sb[0].pc ||
          q_instr_o !== sb[0].instr || count_o !== 3'd1) begin
        errors++;
        $display("FAIL wrap[%0d]: got pc=%h ins=%h cnt=%0d want pc=%h ins=%h cnt=1",
                 i, q_pc_o, q_instr_o, count_o, 32'h100 + 32'(4 * i), sb[0].instr);
      end
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (count_o !== 3'd0 || q_valid_o !== 1'b0 || err_o !== merr) begin
      errors++;
      $display("FAIL wrap_drain: got cnt=%0d v=%b err=%b want 0 0 %b", count_o, q_valid_o, err_o, merr);
    end
  endtask

  task automatic test_flush;
    reset = 0; #2; reset = 1;
    sb.delete(); merr = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1, 32'hC0 + 32'(i), 32'h200 + 32'(4 * i), 0, 0);
    checks++;
    if (count_o !== 3'd3 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: got cnt=%0d err=%b want 3 0", count_o, err_o);
    end
    step(1, 32'hBAD0BAD0, 32'h20C, 2, 1);
    checks++;
    if (count_o !== 3'd0 || q_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 ||
        err_o !== merr || q_instr_o !== 32'h0) begin
      errors++;
      $display("FAIL flush: got cnt=%0d v=%b rdy=%b err=%b ins=%h want 0 0 1 %b 0",
               count_o, q_valid_o, fetch_ready_o, err_o, q_instr_o, merr);
    end
  endtask

  task automatic test_illegal_pop;
    step(1, 32'h0000DEAD, 32'h300, 0, 0);
    step(0, 0, 0, 2, 0);
    checks++;
    if (count_o !== 3'd1 || err_o !== 1'b1 || merr !== 1'b1 || q_pc_o !== 32'h300) begin
      errors++;
      $display("FAIL illegal_pop: got cnt=%0d err=%b pc=%h want 1 1 300", count_o, err_o, q_pc_o);
    end
    step(0, 0, 0, 3, 0);
    checks++;
    if (count_o !== 3'd1 || q_instr_o !== sb[0].instr) begin
      errors++;
      $display("FAIL deq3: got cnt=%0d ins=%h want 1 %h", count_o, q_instr_o, sb[0].instr);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (err_o !== 1'b0 || count_o !== 3'd0 || q_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got err=%b cnt=%0d v=%b want 0 0 0", err_o, count_o, q_valid_o);
    end
    sb.delete(); merr = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_pop2_push;
    test_wrap;
    test_flush;
    test_illegal_pop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/c_fetch_queue.md
Name: c_fetch_queue

Overview:
- Small circular instruction-fetch queue between the icache response path and the compressed-extension stage.
- Buffers 32-bit fetch words with their PCs and exposes the two oldest entries at once, so a 32-bit instruction that straddles a word boundary can be assembled downstream.
- Consumer retires 0, 1 or 2 words per cycle.
- Flushed on taken branch; provides backpressure to fetch.

Parameters:
- DEPTH, 4, number of 32-bit entries; power of two, at least 2.
- XLEN, 32, width of instruction word and PC.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush_i  input  1  taken branch or redirect; discards all queued and incoming words.
- icache_valid_i  input  1  icache response valid this cycle.
- icache_instr_i  input  XLEN  fetched word.
- icache_pc_i  input  XLEN  word-aligned PC of the fetched word; bits [1:0] are ignored and stored as 0.
- fetch_ready_o  output  1  queue can accept a word this cycle.
- deq_cnt_i  input  2  words retired this cycle: 0, 1 or 2. Value 3 is illegal.
- q_valid_o  output  1  entry 0 (oldest) valid.
- q_instr_o  output  XLEN  entry 0 word.
- q_pc_o  output  XLEN  entry 0 PC.
- q_valid2_o  output  1  entry 1 valid.
- q_instr2_o  output  XLEN  entry 1 word.
- count_o  output  $clog2(DEPTH+1)  current occupancy.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- State: read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy register count; storage arrays for instruction and PC; err register.
- Reset (reset=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0, err=0. Storage contents are don't-care.
  - Outputs during and after reset: q_valid_o=0, q_valid2_o=0, q_instr_o, q_pc_o and q_instr2_o all 0 (gated by valid), count_o=0, err_o=0.
  - fetch_ready_o=1, since count=0.
- Reset released mid-operation: queue restarts empty. In-flight icache responses are accepted normally from the first clk edge after reset deasserts.
- fetch_ready_o: combinational, (count < DEPTH). Depends only on registered count. There is no same-cycle pop-to-push bypass, so a full queue that pops in a cycle still refuses a push in that cycle.
- Push condition: push = icache_valid_i & fetch_ready_o & ~flush_i. On push, the word and PC are written at wr_ptr and wr_ptr increments.
- Pop legality: pop is legal when deq_cnt_i <= count and deq_cnt_i != 3.
  - Legal pop: rd_ptr += deq_cnt_i (wrapping).
  - Illegal pop: no pop occurs, and err is set to 1.
- Occupancy update: count_next = count + push - pop_amount. Simultaneous push and pop is allowed at any non-full occupancy.
- Overflow: icache_valid_i=1 while count==DEPTH and flush_i=0 drops the word and sets err.
- Flush (flush_i=1) has priority over push and pop:
  - Next cycle: rd_ptr=0, wr_ptr=0, count=0.
  - Any same-cycle icache word is discarded; deq_cnt_i is ignored.
  - err is not modified. err clears only on reset.
- Peek outputs, all combinational from registers:
  - q_valid_o = (count >= 1); q_valid2_o = (count >= 2).
  - Entry 0 is read at rd_ptr; entry 1 is read at (rd_ptr+1) mod DEPTH.
  - Data outputs are 0 whenever the corresponding valid is 0.
- Latency: a pushed word appears on the outputs in the cycle after the push edge. Empty-queue latency from icache_valid_i to q_valid_o is 1 cycle; there is no combinational pass-through.
- count_o: direct register output.

Test Plan:
1. Reset, then push 0x00000013@0x80000000, 0x00A00093@0x80000004, 0x4501_4581@0x80000008, 0xFFFF_0001@0x8000000C on consecutive cycles, with no dequeue.
   -> count_o reaches 4 and fetch_ready_o=0 from the cycle after the 4th push.
   -> q_instr_o=0x00000013, q_instr2_o=0x00A00093.
2. Full queue, icache_valid_i=1 with deq_cnt_i=1 in the same cycle.
   -> the pushed word is dropped and err_o=1 next cycle; count_o=3.
   -> q_pc_o=0x80000004.
3. Count=2, deq_cnt_i=2 with a simultaneous push of 0x12345678@0x80000010.
   -> next cycle count_o=1, q_instr_o=0x12345678, q_valid2_o=0.
4. Wrap-around, DEPTH=4: run 10 pushes interleaved with deq_cnt_i=1 each cycle, PCs 0x100..0x124.
   -> q_pc_o follows 0x100, 0x104, ... in order across pointer wrap, with no duplicates or skips.
5. Count=3, flush_i=1 together with icache_valid_i=1 and deq_cnt_i=2.
   -> next cycle count_o=0, q_valid_o=0, fetch_ready_o=1, err_o unchanged.
6. Count=1, deq_cnt_i=2.
   -> no pop, count_o stays 1, err_o=1.
   -> asserting reset=0 asynchronously mid-cycle clears err_o and count_o immediately, without waiting for a clock edge.
